count_timer_mc: RTL

//  Multi-channel programmable timer/counter; parametrised successor of the single-mode counters.

---
 rtl/count_timer_mc_pkg.sv | 16 +
 rtl/count_timer_ch.sv | 123 ++++++++++++
 rtl/count_timer_mc.sv | 61 ++++++
 3 files changed

// File: rtl/count_timer_mc_pkg.sv
// Shared mode and direction encodings for the multi-channel timer.
package count_timer_mc_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DN      = 2'b01,
    MODE_UPDN    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/count_timer_ch.sv
// One timer channel: count, direction, terminal/compare events and PWM,
// advanced by a shared prescaler tick.
module count_timer_ch
  import count_timer_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_compare,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf,
  output logic             o_cmp_match,
  output logic             o_pwm_out
);

  logic [WIDTH-1:0] r_count;
  dir_e             r_dir;
  logic             r_ovf;
  logic             r_cmp;
  logic             r_pwm;

  logic [WIDTH-1:0] w_next_count;
  dir_e             w_next_dir;
  logic             w_ovf;
  logic             w_cmp;
  logic             w_step;

  always_comb begin
    w_next_count = r_count;
    w_next_dir   = r_dir;
    w_ovf        = 1'b0;
    w_step       = i_tick & i_en & ~i_load;
    if (i_load) begin
      w_next_count = i_load_value;
      w_next_dir   = DIR_UP;
    end else if (w_step) begin
      case (i_mode)
        MODE_UP: begin
          if (r_count >= i_period) begin
            w_next_count = '0;
            w_ovf        = 1'b1;
          end else begin
            w_next_count = r_count + 1'b1;
          end
        end
        MODE_DN: begin
          if (r_count == '0) begin
            w_next_count = i_period;
            w_ovf        = 1'b1;
          end else begin
            w_next_count = r_count - 1'b1;
          end
        end
        MODE_UPDN: begin
          // A zero period collapses the triangle to a stuck-at-zero counter that
          // reports a terminal event on every step.
          if (i_period == '0) begin
            w_next_count = '0;
            w_next_dir   = DIR_UP;
            w_ovf        = 1'b1;
          end else if (r_dir == DIR_UP) begin
            if (r_count >= i_period) begin
              w_next_dir   = DIR_DOWN;
              w_next_count = i_period - 1'b1;
            end else begin
              w_next_count = r_count + 1'b1;
            end
          end else begin
            if (r_count == '0) begin
              w_next_dir   = DIR_UP;
              w_next_count = WIDTH'(1);
              w_ovf        = 1'b1;
            end else begin
              w_next_count = r_count - 1'b1;
            end
          end
        end
        default: begin
          if (r_count == WIDTH'(1)) begin
            w_next_count = '0;
            w_ovf        = 1'b1;
          end else if (r_count != '0) begin
            w_next_count = r_count - 1'b1;
          end
        end
      endcase
    end
    if (i_mode != MODE_UPDN) begin
      w_next_dir = DIR_UP;
    end
    w_cmp = w_step && (w_next_count == i_compare);
  end

  // PWM compares the count currently held, so it trails the count by one clock.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
      r_dir   <= DIR_UP;
      r_ovf   <= 1'b0;
      r_cmp   <= 1'b0;
      r_pwm   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_dir   <= w_next_dir;
      r_ovf   <= w_ovf;
      r_cmp   <= w_cmp;
      r_pwm   <= (r_count < i_compare);
    end
  end

  assign o_count     = r_count;
  assign o_ovf       = r_ovf;
  assign o_cmp_match = r_cmp;
  assign o_pwm_out   = r_pwm;

endmodule

// File: rtl/count_timer_mc.sv
// Multi-channel timer/counter: one free-running prescaler feeding CHANNELS
// independent count_timer_ch instances.
module count_timer_mc
  import count_timer_mc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESC_WIDTH-1:0]    presc,
  input  logic [CHANNELS-1:0]       en,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH*CHANNELS-1:0] load_value,
  input  logic [WIDTH*CHANNELS-1:0] period,
  input  logic [WIDTH*CHANNELS-1:0] compare,
  output logic [WIDTH*CHANNELS-1:0] count,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       cmp_match,
  output logic [CHANNELS-1:0]       pwm_out
);

  logic [PRESC_WIDTH-1:0] r_presc_cnt;
  logic                   w_tick;

  assign w_tick = (r_presc_cnt == presc);

  // Equality match means a lowered presc lets the counter run on and wrap to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    count_timer_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tick      (w_tick),
      .i_en        (en[g]),
      .i_mode      (mode[2*g +: 2]),
      .i_load      (load[g]),
      .i_load_value(load_value[WIDTH*g +: WIDTH]),
      .i_period    (period[WIDTH*g +: WIDTH]),
      .i_compare   (compare[WIDTH*g +: WIDTH]),
      .o_count     (count[WIDTH*g +: WIDTH]),
      .o_ovf       (ovf[g]),
      .o_cmp_match (cmp_match[g]),
      .o_pwm_out   (pwm_out[g])
    );
  end

endmodule
